sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Single-port SRAM controller and arbiter. Shares one asynchronous 16-bit SRAM between the instruction-fetch (IF) requester and the data-memory (MEM stage) requester.
- Sequences multi-cycle read and write bus cycles with a programmable wait count.
- Produces mem_conflict, the structural-hazard stall that the pipeline hazard unit consumes (pcKeep/ifClear).
- Sits between the IF/MEM stages and the board SRAM pins.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, data width
WAIT_CYCLES, 1, extra cycles the strobe (oe_n/we_n) is held low beyond the first; range 0..7

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
if_req  in  1  IF read request; level, held until if_ack
if_addr  in  ADDR_W  IF read address
if_rdata  out  DATA_W  IF read data; valid when if_ack=1
if_ack  out  1  one-cycle completion pulse for IF
mem_req  in  1  MEM request; level, held until mem_ack
mem_we  in  1  1=write, 0=read
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  MEM write data
mem_rdata  out  DATA_W  MEM read data; valid when mem_ack=1
mem_ack  out  1  one-cycle completion pulse for MEM
mem_conflict  out  1  IF must stall: IF is requesting while MEM owns or claims the SRAM
busy  out  1  state != IDLE
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  DATA_W  write data to the pad
sram_doe  out  1  pad output enable (tristate control)
sram_din  in  DATA_W  read data from the pad
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset (asynchronous, any state): state=IDLE; sram_ce_n=sram_oe_n=sram_we_n=1; sram_doe=0; sram_addr=0; sram_dout=0; if_ack=mem_ack=0; if_rdata=mem_rdata=0; wait counter=0; owner=IF.
- All SRAM control outputs are registered. The strobes never glitch.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE arbitration, strict MEM priority:
  - mem_req=1: owner=MEM; latch mem_addr/mem_we/mem_wdata; go to RD or WR_SETUP.
  - Else if_req=1: owner=IF; latch if_addr; go to RD.
  - Else stay in IDLE.
  - Inputs are sampled only at the grant edge. Later changes are ignored until ACK.
- RD:
  - ce_n=0, oe_n=0, we_n=1, doe=0, addr=latched.
  - Lasts WAIT_CYCLES+1 cycles, counted down.
  - On the final edge, capture sram_din into the owner's rdata register and go to ACK.
- WR_SETUP (1 cycle): ce_n=0, we_n=1, oe_n=1, doe=1, addr and dout stable.
- WR_PULSE (WAIT_CYCLES+1 cycles): we_n=0, doe=1.
- WR_HOLD (1 cycle): we_n=1, doe=1, addr and dout unchanged (hold time). Then go to ACK.
- ACK (1 cycle):
  - The owner's ack=1. ce_n=1, oe_n=1, doe=0.
  - Next state is IDLE. No back-to-back grant from ACK, so there is one idle cycle between transactions.
- Read latency, request seen in IDLE to ack: WAIT_CYCLES+2 cycles. With default 1: grant edge, RD×2, ACK, so ack is high in the 3rd cycle after grant.
- Write latency: WAIT_CYCLES+4 cycles. With default 1: 5 cycles.
- rdata registers hold their value until the next read by the same owner.
- mem_conflict (combinational) = if_req & ((state==IDLE & mem_req) | (state!=IDLE & owner==MEM)). It is 0 during IF-owned transactions.
- Requester drops req mid-transaction: the bus cycle still completes and the ack still pulses. The requester ignores it.
- Both requests in the same IDLE cycle: MEM wins. IF is granted at the first IDLE where mem_req=0.
- doe and we_n are never both active outside WR_*.
- oe_n=0 and doe=1 never occur together.
- WAIT_CYCLES=0 is legal: RD and WR_PULSE each last 1 cycle.

Test Plan:
- IF read, WAIT_CYCLES=1: if_req=1, if_addr=0x00010, model returns 0xBEEF -> oe_n low for exactly 2 cycles; if_ack pulses 1 cycle, 3 cycles after grant; if_rdata=0xBEEF; mem_conflict stays 0.
- MEM write: mem_req=1, mem_we=1, addr=0x3FFFF, wdata=0x1234 -> sequence WR_SETUP(we_n=1), WR_PULSE(we_n=0 for 2 cycles), WR_HOLD(we_n=1); addr and dout stable throughout; model stores 0x1234; mem_ack pulses once.
- Simultaneous: if_req and mem_req (read, 0x00020 returns 0x5A5A) rise in the same cycle -> MEM is served first and mem_conflict=1 until mem_ack. IF is granted at the next IDLE, with one idle cycle between; both acks are seen in that order.
- IF owns the bus when mem_req rises -> IF completes undisturbed; mem_conflict=0 during the IF transaction; MEM is granted at the next IDLE.
- Reset asserted mid-WR_PULSE -> outputs go immediately (asynchronously) to ce_n=we_n=oe_n=1, doe=0, no ack. After release, a fresh read to the same address completes normally.
- WAIT_CYCLES=0 build -> read completes in 2 cycles and write in 4 cycles; returned data is correct.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Single-port controller and arbiter for one asynchronous
//               16-bit SRAM. It is shared between the instruction-fetch (IF)
//               requester and the data-memory (MEM stage) requester. Multi-
//               cycle read and write bus cycles are sequenced with a
//               programmable strobe length. The block also produces the
//               structural-hazard stall (mem_conflict) that the pipeline
//               hazard unit uses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W       SRAM word-address width
//   DATA_W       data width
//   WAIT_CYCLES  extra cycles the read/write strobe is held low beyond the
//                first one (0..7)
// Ports
//   clk, rst                  system clock, asynchronous active-high reset
//   if_req/if_addr            IF read request (level, held until if_ack)
//   if_rdata/if_ack           IF read data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr   MEM request (level, held until mem_ack)
//   mem_wdata                 MEM write data
//   mem_rdata/mem_ack         MEM read data and one-cycle completion pulse
//   mem_conflict              IF must stall because MEM owns/claims the SRAM
//   busy                      a bus cycle is in progress
//   sram_addr/sram_dout       registered address and write data to the pads
//   sram_doe                  pad output enable for the data tristate
//   sram_din                  read data from the pads
//   sram_ce_n/oe_n/we_n       registered active-low SRAM strobes
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // data-memory requester
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  // pipeline status
  output logic              mem_conflict,
  output logic              busy,
  // SRAM pins
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  // --------------------------------------------------------------------------
  // Bus-cycle sequencer states
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_ACK      = 3'd5
  } state_t;

  // Reload value of the strobe-length counter. A strobe phase lasts
  // c_wait_load+1 cycles because the phase ends on the edge where the
  // counter is already zero.
  localparam logic [2:0] c_wait_load = 3'(WAIT_CYCLES);

  state_t     r_state;
  logic       r_owner_mem;  // 1 = MEM owns the current bus cycle, 0 = IF
  logic [2:0] r_cnt;        // remaining extra strobe cycles

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  // IF has to stall when MEM is about to be granted (MEM wins arbitration in
  // IDLE) or while a MEM-owned cycle is running. An IF-owned cycle never
  // stalls IF through this path.
  assign mem_conflict = if_req &
                        (((r_state == S_IDLE) & mem_req) |
                         ((r_state != S_IDLE) & r_owner_mem));

  assign busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Sequencer. Every pin-facing control is a flop, so the strobes change only
  // on clock edges and cannot glitch. Outputs are set on the edge that enters
  // a state, so that they line up with that state's cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_mem <= 1'b0;
      r_cnt       <= 3'd0;
      sram_addr   <= '0;
      sram_dout   <= '0;
      sram_doe    <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      if_ack      <= 1'b0;
      mem_ack     <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
    end else begin
      // Acks are single-cycle pulses. They are raised only on entry to ACK.
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;

      case (r_state)
        // ------------------------------------------------------------------
        // Arbitration with strict MEM priority. Request inputs are latched
        // here only. Later changes have no effect until the cycle finishes.
        // ------------------------------------------------------------------
        S_IDLE: begin
          if (mem_req) begin
            r_owner_mem <= 1'b1;
            sram_addr   <= mem_addr;
            sram_ce_n   <= 1'b0;
            if (mem_we) begin
              // Drive data from the setup cycle so that it is stable well
              // before we_n falls.
              sram_dout <= mem_wdata;
              sram_doe  <= 1'b1;
              r_state   <= S_WR_SETUP;
            end else begin
              sram_oe_n <= 1'b0;
              r_cnt     <= c_wait_load;
              r_state   <= S_RD;
            end
          end else if (if_req) begin
            r_owner_mem <= 1'b0;
            sram_addr   <= if_addr;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b0;
            r_cnt       <= c_wait_load;
            r_state     <= S_RD;
          end
        end

        // ------------------------------------------------------------------
        // Read strobe. The pad data is sampled on the last edge of the
        // strobe, and the owner's ack is raised for the following cycle.
        // ------------------------------------------------------------------
        S_RD: begin
          if (r_cnt == 3'd0) begin
            if (r_owner_mem) begin
              mem_rdata <= sram_din;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata  <= sram_din;
              if_ack    <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            r_state   <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        // One cycle with address/data on the pads before we_n falls.
        S_WR_SETUP: begin
          sram_we_n <= 1'b0;
          r_cnt     <= c_wait_load;
          r_state   <= S_WR_PULSE;
        end

        // Write strobe. The data is committed when we_n rises at the end.
        S_WR_PULSE: begin
          if (r_cnt == 3'd0) begin
            sram_we_n <= 1'b1;
            r_state   <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        // Address and data stay driven one cycle after we_n rises (hold
        // time). The pads are released on entry to ACK.
        S_WR_HOLD: begin
          sram_ce_n <= 1'b1;
          sram_doe  <= 1'b0;
          if (r_owner_mem) begin
            mem_ack <= 1'b1;
          end else begin
            if_ack  <= 1'b1;
          end
          r_state <= S_ACK;
        end

        // The bus is parked for this cycle. There is no grant from ACK, so
        // one idle cycle always separates two transactions.
        S_ACK: begin
          r_state <= S_IDLE;
        end

        // Unreachable encodings: park the bus safely and return to IDLE.
        default: begin
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_doe  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed bench for sram_arbiter. The bench has one instance
//               with WAIT_CYCLES=1 and one with WAIT_CYCLES=0, both on a
//               small behavioural SRAM model. The model is indexed by the low
//               8 address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bus_viol = 0;

  // ---------------- instance with WAIT_CYCLES=1 ----------------
  logic          if_req1, mem_req1, mem_we1;
  logic [AW-1:0] if_addr1, mem_addr1, sram_addr1;
  logic [DW-1:0] mem_wdata1, if_rdata1, mem_rdata1, sram_dout1, sram_din1;
  logic          if_ack1, mem_ack1, conf1, busy1, doe1, ce1, oe1, we1;

  // ---------------- instance with WAIT_CYCLES=0 ----------------
  logic          if_req0, mem_req0, mem_we0;
  logic [AW-1:0] if_addr0, mem_addr0, sram_addr0;
  logic [DW-1:0] mem_wdata0, if_rdata0, mem_rdata0, sram_dout0, sram_din0;
  logic          if_ack0, mem_ack0, conf0, busy0, doe0, ce0, oe0, we0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_ack(mem_ack1), .mem_conflict(conf1), .busy(busy1),
    .sram_addr(sram_addr1), .sram_dout(sram_dout1), .sram_doe(doe1), .sram_din(sram_din1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ack(if_ack0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .mem_ack(mem_ack0), .mem_conflict(conf0), .busy(busy0),
    .sram_addr(sram_addr0), .sram_dout(sram_dout0), .sram_doe(doe0), .sram_din(sram_din0),
    .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0)
  );

  // ---------------- behavioural SRAM ----------------
  logic [DW-1:0] model [0:255];

  assign sram_din1 = (!ce1 && !oe1) ? model[sram_addr1[7:0]] : 16'h0000;
  assign sram_din0 = (!ce0 && !oe0) ? model[sram_addr0[7:0]] : 16'h0000;

  // Writes land while the strobe is low. Bus-rule violations are tallied
  // and checked once at the end.
  always @(negedge clk) begin
    if (!ce1 && !we1 && doe1) model[sram_addr1[7:0]] = sram_dout1;
    if (!ce0 && !we0 && doe0) model[sram_addr0[7:0]] = sram_dout0;
    if ((!oe1 && doe1) || (!we1 && (!doe1 || !oe1))) bus_viol++;
    if ((!oe0 && doe0) || (!we0 && (!doe0 || !oe0))) bus_viol++;
  end

  // ---------------- expected per-cycle tables ----------------
  bit exp_rd_oe  [3] = '{1'b0, 1'b0, 1'b1};
  bit exp_rd_ack [3] = '{1'b0, 1'b0, 1'b1};
  bit exp_wr_we  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  bit exp_wr_doe [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit exp_wr_ce  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  bit exp_wr_ack [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  bit exp_w0_we  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit exp_w0_ack [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic ack_of(input int d, input bit m);
    if (d == 0) return m ? mem_ack0 : if_ack0;
    return m ? mem_ack1 : if_ack1;
  endfunction

  // Counts negedges from the request edge to the ack. -1 means no ack came.
  task automatic wait_ack(input int d, input bit m, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (ack_of(d, m)) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, mack_c, iack_c, mack_n, iack_n;

    if_req1 = 0; mem_req1 = 0; mem_we1 = 0; if_addr1 = '0; mem_addr1 = '0; mem_wdata1 = '0;
    if_req0 = 0; mem_req0 = 0; mem_we0 = 0; if_addr0 = '0; mem_addr0 = '0; mem_wdata0 = '0;
    for (int i = 0; i < 256; i++) model[i] = 16'(i * 3);
    model[8'h10] = 16'hBEEF;
    model[8'h20] = 16'h5A5A;
    model[8'h30] = 16'hAAAA;
    model[8'h40] = 16'h7777;
    model[8'h60] = 16'hC3C3;

    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    #1;
    check_val("rst_strobes1", {ce1, oe1, we1, doe1}, 4'b1110);
    check_val("rst_strobes0", {ce0, oe0, we0, doe0}, 4'b1110);
    check_val("rst_addr_dout", {14'd0, sram_addr1, sram_dout1}, 32'h0);
    check_val("rst_rdata", {if_rdata1, mem_rdata1}, 32'h0);
    check_val("rst_status", {if_ack1, mem_ack1, busy1, conf1}, 4'b0000);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // ---------------- IF read, WAIT_CYCLES=1 ----------------
    if_req1 = 1; if_addr1 = 18'h00010;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      check_val($sformatf("t1_oe_c%0d", cyc), oe1, exp_rd_oe[cyc-1]);
      check_val($sformatf("t1_ce_c%0d", cyc), ce1, exp_rd_oe[cyc-1]);
      check_val($sformatf("t1_ack_c%0d", cyc), if_ack1, exp_rd_ack[cyc-1]);
      check_val($sformatf("t1_conf_c%0d", cyc), conf1, 1'b0);
    end
    check_val("t1_rdata", if_rdata1, 16'hBEEF);
    if_req1 = 0;
    @(negedge clk);
    check_val("t1_ack_pulse", if_ack1, 1'b0);
    check_val("t1_idle", busy1, 1'b0);

    // ---------------- MEM write ----------------
    mem_req1 = 1; mem_we1 = 1; mem_addr1 = 18'h3FFFF; mem_wdata1 = 16'h1234;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      check_val($sformatf("t2_we_c%0d", cyc), we1, exp_wr_we[cyc-1]);
      check_val($sformatf("t2_doe_c%0d", cyc), doe1, exp_wr_doe[cyc-1]);
      check_val($sformatf("t2_ce_c%0d", cyc), ce1, exp_wr_ce[cyc-1]);
      check_val($sformatf("t2_ack_c%0d", cyc), mem_ack1, exp_wr_ack[cyc-1]);
      if (cyc <= 4) begin
        check_val($sformatf("t2_addr_c%0d", cyc), sram_addr1, 18'h3FFFF);
        check_val($sformatf("t2_dout_c%0d", cyc), sram_dout1, 16'h1234);
      end
      // These changes happen after the grant and must be ignored.
      if (cyc == 2) begin mem_addr1 = '0; mem_wdata1 = 16'hFFFF; end
    end
    mem_req1 = 0;
    check_val("t2_stored", model[8'hFF], 16'h1234);
    @(negedge clk);
    check_val("t2_ack_pulse", mem_ack1, 1'b0);

    // ---------------- simultaneous requests ----------------
    if_req1 = 1; if_addr1 = 18'h00040;
    mem_req1 = 1; mem_we1 = 0; mem_addr1 = 18'h00020;
    #1 check_val("t3_conf_c0", conf1, 1'b1);
    mack_c = -1; iack_c = -1; mack_n = 0; iack_n = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      check_val($sformatf("t3_conf_c%0d", cyc), conf1, (cyc <= 3) ? 1'b1 : 1'b0);
      if (cyc == 4) check_val("t3_gap_idle", busy1, 1'b0);
      if (mem_ack1) begin
        mack_n++; mack_c = cyc;
        check_val("t3_mem_rdata", mem_rdata1, 16'h5A5A);
        check_val("t3_if_rdata_held", if_rdata1, 16'hBEEF);
        mem_req1 = 0;
      end
      if (if_ack1) begin
        iack_n++; iack_c = cyc;
        check_val("t3_if_rdata", if_rdata1, 16'h7777);
        if_req1 = 0;
      end
    end
    check_val("t3_mem_ack_cyc", mack_c, 3);
    check_val("t3_if_ack_cyc", iack_c, 7);
    check_val("t3_ack_counts", {mack_n[15:0], iack_n[15:0]}, {16'd1, 16'd1});

    // ---------------- IF owns bus when mem_req rises ----------------
    @(negedge clk);
    if_req1 = 1; if_addr1 = 18'h00010;
    mack_c = -1; iack_c = -1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      check_val($sformatf("t4_conf_c%0d", cyc), conf1, 1'b0);
      if (cyc == 1) begin
        mem_req1 = 1; mem_we1 = 1; mem_addr1 = 18'h00050; mem_wdata1 = 16'h9999;
        if_addr1 = 18'h00020;
      end
      if (if_ack1) begin
        iack_c = cyc;
        check_val("t4_if_rdata", if_rdata1, 16'hBEEF);
        if_req1 = 0;
      end
      if (mem_ack1) begin
        mack_c = cyc;
        mem_req1 = 0;
      end
    end
    check_val("t4_if_ack_cyc", iack_c, 3);
    check_val("t4_mem_ack_cyc", mack_c, 9);
    check_val("t4_stored", model[8'h50], 16'h9999);

    // ---------------- reset in the middle of WR_PULSE ----------------
    mem_req1 = 1; mem_we1 = 1; mem_addr1 = 18'h00030; mem_wdata1 = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    check_val("t5_in_pulse", we1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("t5_async_strobes", {ce1, oe1, we1, doe1}, 4'b1110);
    check_val("t5_async_status", {mem_ack1, busy1}, 2'b00);
    mem_req1 = 0;
    @(negedge clk); rst = 1'b0;
    mack_n = 0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (mem_ack1) mack_n++;
    end
    check_val("t5_no_ack", mack_n, 0);
    mem_req1 = 1; mem_we1 = 0; mem_addr1 = 18'h00030;
    wait_ack(1, 1'b1, 10, c);
    check_val("t5_read_cyc", c, 3);
    check_val("t5_read_data", mem_rdata1, 16'hAAAA);
    mem_req1 = 0;
    @(negedge clk);

    // ---------------- WAIT_CYCLES=0 instance ----------------
    if_req0 = 1; if_addr0 = 18'h00060;
    wait_ack(0, 1'b0, 10, c);
    check_val("t6_rd_cyc", c, 2);
    check_val("t6_rd_data", if_rdata0, 16'hC3C3);
    if_req0 = 0;
    @(negedge clk);
    mem_req0 = 1; mem_we0 = 1; mem_addr0 = 18'h00070; mem_wdata0 = 16'h4242;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      check_val($sformatf("t6_we_c%0d", cyc), we0, exp_w0_we[cyc-1]);
      check_val($sformatf("t6_ack_c%0d", cyc), mem_ack0, exp_w0_ack[cyc-1]);
    end
    mem_req0 = 0;
    check_val("t6_stored", model[8'h70], 16'h4242);
    @(negedge clk);
    mem_req0 = 1; mem_we0 = 0; mem_addr0 = 18'h00070;
    wait_ack(0, 1'b1, 10, c);
    check_val("t6_rb_cyc", c, 2);
    check_val("t6_rb_data", mem_rdata0, 16'h4242);
    mem_req0 = 0;
    @(negedge clk);

    check_val("bus_rules", bus_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
